// File: rtl/periferico_es.sv
// Processor I/O peripheral: a debounced pushbutton latches a switch word for the CPU
// (with a stall handshake), and a separate register holds the CPU's display word.
module periferico_es #(
  parameter int         DATA_WIDTH      = 16,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [1:0] ENTRADA         = 2'b11,
  parameter logic [1:0] SAIDA           = 2'b10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            seletorES,
  input  logic                  botao,
  input  logic [DATA_WIDTH-1:0] chaves,
  input  logic [DATA_WIDTH-1:0] dadoCPU,
  output logic [DATA_WIDTH-1:0] dadoEntrada,
  output logic                  enter,
  output logic                  espera,
  output logic                  entradaValida,
  output logic [DATA_WIDTH-1:0] displaySaida
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {OCIOSO, ESPERA, LIBERA} estado_t;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_deb;
  logic                  r_debPrev;
  logic [CW-1:0]         r_cnt;
  logic                  r_enter;
  estado_t               r_estado;
  logic [DATA_WIDTH-1:0] r_dadoEntrada;
  logic                  r_entradaValida;
  logic [DATA_WIDTH-1:0] r_displaySaida;
  logic                  w_selEntrada;
  logic                  w_selSaida;

  assign w_selEntrada = (seletorES == ENTRADA);
  assign w_selSaida   = (seletorES == SAIDA);

  // The debounced level flips only after the synchronized button has disagreed with it
  // for DEBOUNCE_CYCLES cycles in a row; any agreement restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_debPrev <= 1'b0;
      r_cnt     <= '0;
      r_enter   <= 1'b0;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt >= LP_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_debPrev <= r_deb;
      r_enter   <= r_deb & ~r_debPrev;
    end
  end

  // A capture in ESPERA takes priority over the processor withdrawing its request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado        <= OCIOSO;
      r_dadoEntrada   <= '0;
      r_entradaValida <= 1'b0;
    end else begin
      r_entradaValida <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_selEntrada) r_estado <= ESPERA;
        end
        ESPERA: begin
          if (r_enter) begin
            r_dadoEntrada   <= chaves;
            r_entradaValida <= 1'b1;
            r_estado        <= LIBERA;
          end else if (!w_selEntrada) begin
            r_estado <= OCIOSO;
          end
        end
        LIBERA: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_displaySaida <= '0;
    end else if (w_selSaida) begin
      r_displaySaida <= dadoCPU;
    end
  end

  // Stall is raised in the same cycle the processor first selects input.
  assign espera        = (r_estado == ESPERA) | ((r_estado == OCIOSO) & w_selEntrada);
  assign dadoEntrada   = r_dadoEntrada;
  assign enter         = r_enter;
  assign entradaValida = r_entradaValida;
  assign displaySaida  = r_displaySaida;

endmodule

// File: tb/tb_periferico_es.sv
// Directed bench for periferico_es: a per-cycle vector table for a clean press and the
// output register, then hand-written bounce, held-button, abort and reset sequences.
module tb_periferico_es;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    seletorES;
  logic          botao;
  logic [DW-1:0] chaves;
  logic [DW-1:0] dadoCPU;
  logic [DW-1:0] dadoEntrada;
  logic          enter;
  logic          espera;
  logic          entradaValida;
  logic [DW-1:0] displaySaida;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [1:0]    sel;
    logic          btn;
    logic [DW-1:0] sw;
    logic [DW-1:0] cpu;
    logic          expComb;
    logic          expEnter;
    logic          expValid;
    logic          expEspera;
    logic [DW-1:0] expDado;
    logic [DW-1:0] expDisp;
  } vec_t;

  vec_t vecs[19];

  periferico_es #(
    .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(4), .ENTRADA(2'b11), .SAIDA(2'b10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .seletorES(seletorES), .botao(botao),
    .chaves(chaves), .dadoCPU(dadoCPU), .dadoEntrada(dadoEntrada), .enter(enter),
    .espera(espera), .entradaValida(entradaValida), .displaySaida(displaySaida)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    seletorES = v.sel;
    botao     = v.btn;
    chaves    = v.sw;
    dadoCPU   = v.cpu;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic runCycles(input int n, output int enterFirst, output int enterCount, output int validCount);
    enterFirst = 0;
    enterCount = 0;
    validCount = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (enter === 1'b1) begin
        enterCount++;
        if (enterFirst == 0) enterFirst = c;
      end
      if (entradaValida === 1'b1) validCount++;
    end
  endtask

  initial begin
    int ef, ec, vc;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{2'b11, 1'b1, 16'h00A5, 16'h0000, 1'b1, (i == 6), (i == 7), (i != 7),
                  ((i == 7) ? 16'h00A5 : 16'h0000), 16'h0000};
    vecs[8]  = '{2'b00, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0000};
    vecs[9]  = '{2'b10, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h1234};
    vecs[10] = '{2'b00, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h1234};
    vecs[11] = '{2'b01, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h1234};
    for (int i = 12; i < 19; i++)
      vecs[i] = '{2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5, 16'h1234};

    reset_n   = 1'b1;
    seletorES = 2'b00;
    botao     = 1'b0;
    chaves    = '0;
    dadoCPU   = '0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset dadoEntrada", dadoEntrada, 16'h0000);
    checkOutput("reset displaySaida", displaySaida, 16'h0000);
    checkBit("reset enter", enter, 1'b0);
    checkBit("reset entradaValida", entradaValida, 1'b0);
    checkBit("reset espera sel00", espera, 1'b0);
    seletorES = 2'b11;
    #1 checkBit("reset espera sel11", espera, 1'b1);
    seletorES = 2'b00;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    $display("[TB] vector table: clean press and output register");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      #1 checkBit($sformatf("row%0d espera comb", i), espera, vecs[i].expComb);
      tick();
      checkBit($sformatf("row%0d enter", i), enter, vecs[i].expEnter);
      checkBit($sformatf("row%0d entradaValida", i), entradaValida, vecs[i].expValid);
      checkBit($sformatf("row%0d espera", i), espera, vecs[i].expEspera);
      checkOutput($sformatf("row%0d dadoEntrada", i), dadoEntrada, vecs[i].expDado);
      checkOutput($sformatf("row%0d displaySaida", i), displaySaida, vecs[i].expDisp);
    end

    $display("[TB] bounce");
    seletorES = 2'b11;
    chaves    = 16'h5A5A;
    ec = 0;
    for (int i = 0; i < 20; i++) begin
      botao = ((i / 2) % 2 == 0);
      tick();
      if (enter === 1'b1) ec++;
    end
    checkInt("bounce enter during bounce", ec, 0);
    botao = 1'b1;
    runCycles(12, ef, ec, vc);
    checkInt("bounce enter first", ef, 7);
    checkInt("bounce enter count", ec, 1);
    checkInt("bounce valid count", vc, 1);
    checkOutput("bounce dadoEntrada", dadoEntrada, 16'h5A5A);
    seletorES = 2'b00;
    botao     = 1'b0;
    runCycles(10, ef, ec, vc);

    $display("[TB] held button");
    seletorES = 2'b11;
    chaves    = 16'h1111;
    botao     = 1'b1;
    runCycles(8, ef, ec, vc);
    checkInt("held first enter", ef, 7);
    checkInt("held first valid", vc, 1);
    checkBit("held valid at capture", entradaValida, 1'b1);
    checkOutput("held first capture", dadoEntrada, 16'h1111);
    seletorES = 2'b00;
    tick();
    seletorES = 2'b11;
    chaves    = 16'h2222;
    runCycles(60, ef, ec, vc);
    checkInt("held no second enter", ec, 0);
    checkInt("held no second valid", vc, 0);
    checkOutput("held dadoEntrada kept", dadoEntrada, 16'h1111);
    checkBit("held espera stalled", espera, 1'b1);
    botao = 1'b0;
    runCycles(10, ef, ec, vc);
    checkInt("held release no enter", ec, 0);
    botao = 1'b1;
    runCycles(8, ef, ec, vc);
    checkInt("held repress enter", ef, 7);
    checkInt("held repress valid", vc, 1);
    checkOutput("held second capture", dadoEntrada, 16'h2222);
    seletorES = 2'b00;
    botao     = 1'b0;
    runCycles(10, ef, ec, vc);

    $display("[TB] abort");
    seletorES = 2'b11;
    chaves    = 16'hBEEF;
    tick();
    checkBit("abort espera in ESPERA", espera, 1'b1);
    seletorES = 2'b00;
    #1 checkBit("abort espera comb", espera, 1'b1);
    tick();
    checkBit("abort espera after", espera, 1'b0);
    checkBit("abort no valid", entradaValida, 1'b0);
    checkOutput("abort dadoEntrada kept", dadoEntrada, 16'h2222);
    botao = 1'b1;
    runCycles(10, ef, ec, vc);
    checkInt("abort idle enter seen", ec, 1);
    checkInt("abort idle no valid", vc, 0);
    seletorES = 2'b11;
    runCycles(15, ef, ec, vc);
    checkInt("abort discarded enter", vc, 0);
    checkOutput("abort dadoEntrada still", dadoEntrada, 16'h2222);
    checkBit("abort espera waiting", espera, 1'b1);
    seletorES = 2'b00;
    botao     = 1'b0;
    runCycles(10, ef, ec, vc);

    $display("[TB] reset mid-debounce");
    seletorES = 2'b11;
    chaves    = 16'h3333;
    botao     = 1'b1;
    runCycles(4, ef, ec, vc);
    checkInt("rst pre enter", ec, 0);
    reset_n   = 1'b0;
    seletorES = 2'b00;
    #1;
    checkOutput("rst dadoEntrada", dadoEntrada, 16'h0000);
    checkOutput("rst displaySaida", displaySaida, 16'h0000);
    checkBit("rst enter", enter, 1'b0);
    checkBit("rst entradaValida", entradaValida, 1'b0);
    checkBit("rst espera", espera, 1'b0);
    runCycles(3, ef, ec, vc);
    checkInt("rst enter during", ec, 0);
    checkOutput("rst held displaySaida", displaySaida, 16'h0000);
    seletorES = 2'b11;
    #1 checkBit("rst espera follows sel", espera, 1'b1);
    reset_n = 1'b1;
    runCycles(7, ef, ec, vc);
    checkInt("rst fresh enter", ef, 7);
    checkInt("rst fresh enter count", ec, 1);
    seletorES = 2'b00;
    tick();
    checkBit("coincide valid", entradaValida, 1'b1);
    checkOutput("coincide capture", dadoEntrada, 16'h3333);
    checkBit("coincide espera", espera, 1'b0);
    tick();
    checkBit("coincide back idle", entradaValida, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
